// File: rtl/spi_cnn_slave_param.sv
// SPI mode-0 slave that loads CNN image rows/weights, starts the CNN and reads back result/status.
// Word writes land 3 i_CLOCK cycles after the SPI rise; no backpressure (excess words are dropped, ovf set).
module spi_cnn_slave_param #(
    parameter int N_ROWS       = 8,
    parameter int ROW_WIDTH    = 8,
    parameter int N_WEIGHTS    = 9,
    parameter int WEIGHT_WIDTH = 8,
    parameter int RESULT_WIDTH = 4
) (
    input  logic                              i_CLOCK,
    input  logic                              i_RESET,
    input  logic                              i_SPI_Clk,
    input  logic                              i_SPI_CS_n,
    input  logic                              i_SPI_MOSI,
    output logic                              o_SPI_MISO,
    output logic                              o_SPI_MISO_oe,
    input  logic                              i_cnn_done,
    input  logic [RESULT_WIDTH-1:0]           i_cnn_result,
    output logic                              o_start_cnn,
    output logic [N_ROWS*ROW_WIDTH-1:0]       o_rows,
    output logic [N_ROWS-1:0]                 o_load,
    output logic [N_WEIGHTS*WEIGHT_WIDTH-1:0] o_weights
);

    localparam int SW0 = (ROW_WIDTH > WEIGHT_WIDTH) ? ROW_WIDTH : WEIGHT_WIDTH;
    localparam int SW  = (SW0 > 3) ? SW0 : 3;
    localparam int CW  = $clog2(SW + 1);
    localparam int RDW = (RESULT_WIDTH > 8) ? RESULT_WIDTH : 8;
    localparam int RPW = $clog2(N_ROWS + 1);
    localparam int WPW = $clog2(N_WEIGHTS + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] OPCODE   = 3'd1;
    localparam logic [2:0] LOAD_IMG = 3'd2;
    localparam logic [2:0] LOAD_WGT = 3'd3;
    localparam logic [2:0] READ     = 3'd4;
    localparam logic [2:0] DISCARD  = 3'd5;

    logic [1:0]                        r_sclk_sync;
    logic [1:0]                        r_cs_sync;
    logic [1:0]                        r_mosi_sync;
    logic                              r_sclk_d;
    logic                              r_cs_d;
    logic [1:0]                        r_settle;
    logic                              r_armed;
    logic [2:0]                        r_state;
    logic [CW-1:0]                     r_bit_cnt;
    logic [SW-2:0]                     r_hist;
    logic [RPW-1:0]                    r_row_ptr;
    logic [WPW-1:0]                    r_wgt_ptr;
    logic [N_ROWS*ROW_WIDTH-1:0]       r_rows;
    logic [N_WEIGHTS*WEIGHT_WIDTH-1:0] r_weights;
    logic [N_ROWS-1:0]                 r_load;
    logic                              r_start;
    logic [RESULT_WIDTH-1:0]           r_result;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_ovf;
    logic [RDW-1:0]                    r_rd_shift;
    logic                              r_oe;

    logic          w_sclk;
    logic          w_cs_n;
    logic          w_mosi;
    logic          w_rise;
    logic          w_fall;
    logic          w_cs_fall;
    logic          w_cs_rise;
    logic [SW-1:0] w_word;
    logic [2:0]    w_opcode;
    logic [7:0]    w_status;

    assign w_sclk    = r_sclk_sync[1];
    assign w_cs_n    = r_cs_sync[1];
    assign w_mosi    = r_mosi_sync[1];
    assign w_rise    = w_sclk & ~r_sclk_d;
    assign w_fall    = ~w_sclk & r_sclk_d;
    // A frame may only start once CS_n has been seen high with the synchronizer flushed after reset.
    assign w_cs_fall = r_armed & ~w_cs_n & r_cs_d;
    assign w_cs_rise = w_cs_n & ~r_cs_d;
    assign w_word    = {r_hist, w_mosi};
    assign w_opcode  = w_word[2:0];
    assign w_status  = {5'b0, r_ovf, r_done, r_busy};

    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_settle    <= 2'd0;
            r_armed     <= 1'b0;
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_hist      <= '0;
            r_row_ptr   <= '0;
            r_wgt_ptr   <= '0;
            r_rows      <= '0;
            r_weights   <= '0;
            r_load      <= '0;
            r_start     <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_rd_shift  <= '0;
            r_oe        <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_SPI_Clk};
            r_cs_sync   <= {r_cs_sync[0], i_SPI_CS_n};
            r_mosi_sync <= {r_mosi_sync[0], i_SPI_MOSI};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs_n;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end else if (w_cs_n) begin
                r_armed <= 1'b1;
            end
            r_load  <= '0;
            r_start <= 1'b0;

            if (w_cs_rise) begin
                r_state <= IDLE;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= OPCODE;
                            r_bit_cnt <= '0;
                            r_row_ptr <= '0;
                            r_wgt_ptr <= '0;
                        end
                    end
                    OPCODE: begin
                        if (w_rise) begin
                            r_hist <= w_word[SW-2:0];
                            if (r_bit_cnt == CW'(2)) begin
                                r_bit_cnt <= '0;
                                case (w_opcode)
                                    3'b000: r_state <= LOAD_IMG;
                                    3'b001: r_state <= LOAD_WGT;
                                    3'b010: begin
                                        r_state <= DISCARD;
                                        if (!r_busy) begin
                                            r_start <= 1'b1;
                                            r_busy  <= 1'b1;
                                            r_done  <= 1'b0;
                                        end
                                    end
                                    3'b011: begin
                                        r_state    <= READ;
                                        r_oe       <= 1'b1;
                                        r_rd_shift <= RDW'(r_result) << (RDW - RESULT_WIDTH);
                                        r_done     <= 1'b0;
                                    end
                                    3'b100: begin
                                        r_state    <= READ;
                                        r_oe       <= 1'b1;
                                        r_rd_shift <= RDW'(w_status) << (RDW - 8);
                                        r_ovf      <= 1'b0;
                                    end
                                    default: r_state <= DISCARD;
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CW'(1);
                            end
                        end
                    end
                    LOAD_IMG: begin
                        if (w_rise) begin
                            r_hist <= w_word[SW-2:0];
                            if (r_bit_cnt == CW'(ROW_WIDTH - 1)) begin
                                r_bit_cnt <= '0;
                                if (r_row_ptr < RPW'(N_ROWS)) begin
                                    r_rows[int'(r_row_ptr)*ROW_WIDTH +: ROW_WIDTH] <= w_word[ROW_WIDTH-1:0];
                                    r_load    <= N_ROWS'(1) << r_row_ptr;
                                    r_row_ptr <= r_row_ptr + RPW'(1);
                                end else begin
                                    r_ovf   <= 1'b1;
                                    r_state <= DISCARD;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CW'(1);
                            end
                        end
                    end
                    LOAD_WGT: begin
                        if (w_rise) begin
                            r_hist <= w_word[SW-2:0];
                            if (r_bit_cnt == CW'(WEIGHT_WIDTH - 1)) begin
                                r_bit_cnt <= '0;
                                if (r_wgt_ptr < WPW'(N_WEIGHTS)) begin
                                    r_weights[int'(r_wgt_ptr)*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= w_word[WEIGHT_WIDTH-1:0];
                                    r_wgt_ptr <= r_wgt_ptr + WPW'(1);
                                end else begin
                                    r_ovf   <= 1'b1;
                                    r_state <= DISCARD;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CW'(1);
                            end
                        end
                    end
                    READ: begin
                        // Zero fill means MISO naturally drives 0 once the word is exhausted.
                        if (w_fall) begin
                            r_rd_shift <= r_rd_shift << 1;
                        end
                    end
                    default: ;
                endcase
            end

            if (i_cnn_done) begin
                r_result <= i_cnn_result;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign o_SPI_MISO    = r_oe & r_rd_shift[RDW-1];
    assign o_SPI_MISO_oe = r_oe;
    assign o_start_cnn   = r_start;
    assign o_rows        = r_rows;
    assign o_load        = r_load;
    assign o_weights     = r_weights;

endmodule

// File: tb/tb_spi_cnn_slave_param.sv
// Randomized frame-level bench for spi_cnn_slave_param against an array/flag model of the register file.
module tb_spi_cnn_slave_param;

    localparam int NR   = 8;
    localparam int RWD  = 8;
    localparam int NW   = 9;
    localparam int WW   = 8;
    localparam int RSW  = 4;
    localparam int HALF = 50;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclk, cs_n, mosi;
    logic              miso, miso_oe;
    logic              cnn_done;
    logic [RSW-1:0]    cnn_result;
    logic              start_cnn;
    logic [NR*RWD-1:0] rows;
    logic [NR-1:0]     load;
    logic [NW*WW-1:0]  weights;

    spi_cnn_slave_param #(
        .N_ROWS(NR), .ROW_WIDTH(RWD), .N_WEIGHTS(NW), .WEIGHT_WIDTH(WW), .RESULT_WIDTH(RSW)
    ) dut (
        .i_CLOCK(clk), .i_RESET(rst),
        .i_SPI_Clk(sclk), .i_SPI_CS_n(cs_n), .i_SPI_MOSI(mosi),
        .o_SPI_MISO(miso), .o_SPI_MISO_oe(miso_oe),
        .i_cnn_done(cnn_done), .i_cnn_result(cnn_result),
        .o_start_cnn(start_cnn), .o_rows(rows), .o_load(load), .o_weights(weights)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the slave's visible state
    logic [RWD-1:0] m_rows [NR];
    logic [WW-1:0]  m_wgts [NW];
    logic           m_ovf, m_done, m_busy;
    logic [RSW-1:0] m_result;

    function automatic logic [NR*RWD-1:0] exp_rows();
        logic [NR*RWD-1:0] v;
        for (int r = 0; r < NR; r++) v[r*RWD +: RWD] = m_rows[r];
        return v;
    endfunction

    function automatic logic [NW*WW-1:0] exp_wgts();
        logic [NW*WW-1:0] v;
        for (int w = 0; w < NW; w++) v[w*WW +: WW] = m_wgts[w];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_rows[r] = '0;
        for (int w = 0; w < NW; w++) m_wgts[w] = '0;
        m_ovf = 0; m_done = 0; m_busy = 0; m_result = '0;
    endtask

    int            start_cnt = 0;
    logic [NR-1:0] load_q[$];
    always @(negedge clk) begin
        if (start_cnn) start_cnt++;
        if (|load) load_q.push_back(load);
    end

    logic tx_q[$];
    logic miso_q[$];
    logic oe_q[$];

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
    endtask

    // One mode-0 bit; MISO/OE sampled just before the falling edge.
    task automatic spi_bit(input logic b);
        mosi = b;
        #HALF sclk = 1'b1;
        #HALF;
        miso_q.push_back(miso);
        oe_q.push_back(miso_oe);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input int nbits);
        miso_q.delete();
        oe_q.delete();
        @(negedge clk);
        cs_n = 1'b0;
        #HALF;
        for (int k = 0; k < nbits; k++) spi_bit(tx_q[k]);
        #HALF;
        cs_n = 1'b1;
        mosi = 1'b0;
        #(4*HALF);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_rows"}, rows, '0);
        check_eq({pfx, "_weights"}, weights, '0);
        check_eq({pfx, "_load"}, load, '0);
        check_eq({pfx, "_start"}, start_cnn, 1'b0);
        check_eq({pfx, "_miso"}, miso, 1'b0);
        check_eq({pfx, "_oe"}, miso_oe, 1'b0);
    endtask

    task automatic img_frame(input int nbytes, input bit fixed);
        logic [7:0] b;
        int nexp;
        bit ok;
        tx_q.delete();
        push_bits(32'b000, 3);
        for (int i = 0; i < nbytes; i++) begin
            b = fixed ? 8'(i + 1) : 8'($urandom);
            push_bits({24'b0, b}, 8);
            if (i < NR) m_rows[i] = b;
            else m_ovf = 1'b1;
        end
        load_q.delete();
        spi_frame(3 + 8*nbytes);
        nexp = (nbytes < NR) ? nbytes : NR;
        check_eq("load_count", load_q.size(), nexp);
        ok = 1'b1;
        for (int i = 0; i < load_q.size() && i < nexp; i++)
            if (load_q[i] !== (NR'(1) << i)) ok = 1'b0;
        check_eq("load_order", ok, 1'b1);
        check_eq("rows", rows, exp_rows());
    endtask

    task automatic wgt_frame(input int nbytes, input int abort_bits);
        logic [7:0] b;
        int nsend;
        tx_q.delete();
        push_bits(32'b001, 3);
        nsend = (abort_bits >= 0) ? abort_bits : 3 + 8*nbytes;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            push_bits({24'b0, b}, 8);
            if (3 + 8*(i + 1) <= nsend) begin
                if (i < NW) m_wgts[i] = b;
                else m_ovf = 1'b1;
            end
        end
        load_q.delete();
        spi_frame(nsend);
        check_eq("wgt_no_load", load_q.size(), 0);
        check_eq("weights", weights, exp_wgts());
    endtask

    task automatic start_frame();
        int s0;
        int exp_pulses;
        tx_q.delete();
        push_bits(32'b010, 3);
        push_bits($urandom, 5);
        exp_pulses = m_busy ? 0 : 1;
        if (!m_busy) begin
            m_busy = 1'b1;
            m_done = 1'b0;
        end
        s0 = start_cnt;
        spi_frame(8);
        check_eq("start_pulses", start_cnt - s0, exp_pulses);
    endtask

    task automatic pulse_done(input logic [RSW-1:0] res);
        @(negedge clk);
        cnn_done   = 1'b1;
        cnn_result = res;
        @(negedge clk);
        cnn_done   = 1'b0;
        cnn_result = '0;
        m_result = res;
        m_busy   = 1'b0;
        m_done   = 1'b1;
    endtask

    task automatic read_frame(input logic [2:0] op);
        logic [7:0]  exp_w, got;
        logic [10:0] got_oe;
        tx_q.delete();
        push_bits({29'b0, op}, 3);
        push_bits($urandom, 8);
        if (op == 3'b100) begin
            exp_w = {5'b0, m_ovf, m_done, m_busy};
            m_ovf = 1'b0;
        end else begin
            exp_w = {m_result, 4'b0};
            m_done = 1'b0;
        end
        spi_frame(11);
        got = '0;
        for (int k = 2; k < 10; k++) got = {got[6:0], miso_q[k]};
        for (int k = 0; k < 11; k++) got_oe[10-k] = oe_q[k];
        check_eq((op == 3'b100) ? "status_rd" : "result_rd", got, exp_w);
        check_eq("read_oe", got_oe, 11'b00111111111);
        check_eq("oe_after_frame", {miso_oe, miso}, 2'b00);
    endtask

    task automatic junk_frame();
        logic [2:0] op;
        int s0;
        logic any_oe, any_miso;
        op = 3'(5 + $urandom_range(0, 2));
        tx_q.delete();
        push_bits({29'b0, op}, 3);
        push_bits($urandom, 16);
        s0 = start_cnt;
        load_q.delete();
        spi_frame(19);
        any_oe = 1'b0;
        any_miso = 1'b0;
        for (int k = 0; k < 19; k++) begin
            any_oe   |= oe_q[k];
            any_miso |= miso_q[k];
        end
        check_eq("junk_oe", {any_oe, any_miso}, 2'b00);
        check_eq("junk_start", start_cnt - s0, 0);
        check_eq("junk_load", load_q.size(), 0);
        check_eq("junk_rows", rows, exp_rows());
        check_eq("junk_wgts", weights, exp_wgts());
    endtask

    task automatic reset_mid_frame();
        tx_q.delete();
        push_bits(32'b000, 3);
        for (int i = 0; i < 4; i++) push_bits($urandom, 8);
        @(negedge clk);
        cs_n = 1'b0;
        #HALF;
        for (int k = 0; k < 3 + 24 + 4; k++) spi_bit(tx_q[k]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        load_q.delete();
        for (int k = 31; k < 35; k++) spi_bit(tx_q[k]);
        #HALF;
        cs_n = 1'b1;
        #(4*HALF);
        check_eq("postrst_no_load", load_q.size(), 0);
        check_eq("postrst_rows", rows, '0);
        img_frame(2, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cnn_done = 1'b0; cnn_result = '0;
        model_reset();
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        read_frame(3'b100);
        img_frame(8, 1'b1);
        img_frame(9, 1'b0);
        read_frame(3'b100);
        read_frame(3'b100);

        start_frame();
        read_frame(3'b100);
        start_frame();
        pulse_done(4'hA);
        read_frame(3'b011);
        read_frame(3'b100);

        wgt_frame(9, -1);
        wgt_frame(4, 3 + 8*3 + 4);
        read_frame(3'b100);

        junk_frame();
        reset_mid_frame();
        read_frame(3'b100);

        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 6))
                0: img_frame($urandom_range(1, 10), 1'b0);
                1: wgt_frame($urandom_range(1, 11), -1);
                2: start_frame();
                3: pulse_done(RSW'($urandom));
                4: read_frame(3'b100);
                5: read_frame(3'b011);
                default: junk_frame();
            endcase
        end
        read_frame(3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
